// File: rtl/cpu_mem_pkg.sv
// Shared constants and types for the accumulator CPU memory bus.
// Opcode values are shared with the CPU controller.
package cpu_mem_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_HOLD = 2'd2
  } rsp_state_t;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

endpackage

// File: rtl/cpu_mem_responder_if.sv
// CPU-side memory bus plus the preload side port, with master (CPU/loader)
// and slave (responder) views.
interface cpu_mem_responder_if #(
  parameter int ADDR_W = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W = cpu_mem_pkg::DATA_W
);
  import cpu_mem_pkg::*;

  // Handshake: the master holds rd high with a stable addr; the responder
  // raises data_valid once data_out holds mem[addr] and keeps both stable until
  // rd falls or addr changes. wr is a single-cycle strobe, qualified by data_e.
  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] data_in;
  logic              data_e;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              proto_err;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_busy;
  rsp_state_t        dbg_state;

  modport master (
    output addr, rd, wr, data_in, data_e, ld_en, ld_addr, ld_data,
    input  data_out, data_valid, proto_err, ld_busy, dbg_state
  );

  modport slave (
    input  addr, rd, wr, data_in, data_e, ld_en, ld_addr, ld_data,
    output data_out, data_valid, proto_err, ld_busy, dbg_state
  );

endinterface

// File: rtl/cpu_mem_array.sv
// Word store: one write port, one registered read port. The storage itself is
// never cleared; only the read register resets.
module cpu_mem_array #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read and write on the same edge: the read sees the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory responder for the accumulator CPU: read-latency FSM, protocol checker
// and preload arbitration. Define MEM_WRPROT_EN to make addr < PROT_LIMIT read-only to CPU writes.
module cpu_mem_responder #(
  parameter int ADDR_W     = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W     = cpu_mem_pkg::DATA_W,
  parameter int READ_LAT   = 1,
  parameter int PROT_LIMIT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  cpu_mem_responder_if.slave  bus
);
  import cpu_mem_pkg::*;

`ifdef MEM_WRPROT_EN
  localparam bit WRPROT = 1'b1;
`else
  localparam bit WRPROT = 1'b0;
`endif
  localparam logic [ADDR_W:0] PROT_LIM = (ADDR_W + 1)'(PROT_LIMIT);
  localparam logic [1:0]      LAT_INIT = 2'(READ_LAT - 1);

  rsp_state_t        state_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic              rd_q;
  logic              valid_q;
  logic              proto_err_q;
  logic              ld_busy_q;

  logic              rd_start, rd_fire, prot_hit, err_d, cpu_we, ld_ok, ld_busy_d;
  logic              mem_we;
  logic [ADDR_W-1:0] raddr, waddr;
  logic [DATA_W-1:0] wdata, rdata;

  always_comb begin
    rd_start  = bus.rd && (!rd_q || (bus.addr != lat_addr_q));
    prot_hit  = WRPROT && ({1'b0, bus.addr} < PROT_LIM);
    err_d     = bus.wr && (bus.rd || !bus.data_e || prot_hit);
    cpu_we    = bus.wr && !err_d;
    ld_ok     = bus.ld_en && !bus.rd && !bus.wr && (state_q == IDLE);
    ld_busy_d = bus.ld_en && !ld_ok;
    mem_we    = cpu_we || ld_ok;
    waddr     = cpu_we ? bus.addr : bus.ld_addr;
    wdata     = cpu_we ? bus.data_in : bus.ld_data;
    raddr     = rd_start ? bus.addr : lat_addr_q;
    // Single-cycle latency fetches on the start edge; otherwise the last WAIT cycle fetches.
    if (rd_start) rd_fire = (READ_LAT == 1);
    else          rd_fire = (state_q == RD_WAIT) && bus.rd && (cnt_q <= 2'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      lat_addr_q  <= '0;
      rd_q        <= 1'b0;
      valid_q     <= 1'b0;
      proto_err_q <= 1'b0;
      ld_busy_q   <= 1'b0;
    end else begin
      rd_q      <= bus.rd;
      ld_busy_q <= ld_busy_d;
      if (err_d) proto_err_q <= 1'b1;
      if (rd_start) begin
        lat_addr_q <= bus.addr;
        cnt_q      <= LAT_INIT;
        if (READ_LAT == 1) begin
          state_q <= RD_HOLD;
          valid_q <= 1'b1;
        end else begin
          state_q <= RD_WAIT;
          valid_q <= 1'b0;
        end
      end else begin
        case (state_q)
          IDLE: valid_q <= 1'b0;
          RD_WAIT: begin
            if (!bus.rd) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end else if (cnt_q <= 2'd1) begin
              state_q <= RD_HOLD;
              valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 2'd1;
            end
          end
          RD_HOLD: begin
            if (!bus.rd) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  cpu_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .re_i    (rd_fire),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign bus.data_out   = rdata;
  assign bus.data_valid = valid_q;
  assign bus.proto_err  = proto_err_q;
  assign bus.ld_busy    = ld_busy_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: a vector table on a READ_LAT=1 instance,
// hand sequences for reset, protocol errors, write protect and READ_LAT=2 timing.
module tb_cpu_mem_responder;
  import cpu_mem_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_mem_responder_if #(.ADDR_W(5), .DATA_W(8)) b1 ();
  cpu_mem_responder_if #(.ADDR_W(5), .DATA_W(8)) b2 ();

  cpu_mem_responder #(.ADDR_W(5), .DATA_W(8), .READ_LAT(1), .PROT_LIMIT(16)) u_lat1 (
    .clk (clk), .rst_n (rst_n), .bus (b1.slave)
  );
  cpu_mem_responder #(.ADDR_W(5), .DATA_W(8), .READ_LAT(2), .PROT_LIMIT(16)) u_lat2 (
    .clk (clk), .rst_n (rst_n), .bus (b2.slave)
  );

`ifdef MEM_WRPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  typedef struct {
    logic       rd, wr, de;
    logic [4:0] addr;
    logic [7:0] din;
    logic       ld;
    logic [4:0] la;
    logic [7:0] ldd;
    logic       ev;
    logic [7:0] ed;
    logic       ee;
    logic       eb;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  // scoreboard
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic de,
                              input logic [4:0] a, input logic [7:0] d,
                              input logic ld, input logic [4:0] la, input logic [7:0] ldd,
                              input logic ev, input logic [7:0] ed,
                              input logic ee, input logic eb);
    vec_t v;
    v.rd = rd; v.wr = wr; v.de = de; v.addr = a; v.din = d;
    v.ld = ld; v.la = la; v.ldd = ldd;
    v.ev = ev; v.ed = ed; v.ee = ee; v.eb = eb;
    return v;
  endfunction

  // driver tasks
  task automatic drive1(input logic rd, input logic wr, input logic de,
                        input logic [4:0] a, input logic [7:0] d,
                        input logic ld, input logic [4:0] la, input logic [7:0] ldd);
    b1.rd = rd; b1.wr = wr; b1.data_e = de; b1.addr = a; b1.data_in = d;
    b1.ld_en = ld; b1.ld_addr = la; b1.ld_data = ldd;
  endtask

  task automatic drive2(input logic rd, input logic wr, input logic de,
                        input logic [4:0] a, input logic [7:0] d,
                        input logic ld, input logic [4:0] la, input logic [7:0] ldd);
    b2.rd = rd; b2.wr = wr; b2.data_e = de; b2.addr = a; b2.data_in = d;
    b2.ld_en = ld; b2.ld_addr = la; b2.ld_data = ldd;
  endtask

  task automatic cyc1(input logic rd, input logic wr, input logic de,
                      input logic [4:0] a, input logic [7:0] d,
                      input logic ld, input logic [4:0] la, input logic [7:0] ldd);
    @(negedge clk);
    drive1(rd, wr, de, a, d, ld, la, ldd);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc2(input logic rd, input logic [4:0] a,
                      input logic ld, input logic [4:0] la, input logic [7:0] ldd);
    @(negedge clk);
    drive2(rd, 1'b0, 1'b0, a, 8'h00, ld, la, ldd);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    drive1(0, 0, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00);
    rst_n = 1'b0;
    #1;
    check("rst err", 32'(b1.proto_err), 32'd0);
    check("rst valid", 32'(b1.data_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // rd, wr, de, addr, din, ld, la, ldd, exp_valid, exp_data, exp_err, exp_busy
    vecs[0]  = mk(0, 0, 0, 5'd0,  8'h00, 1, 5'd3,  8'hA5, 0, 8'h00, 0, 0);
    vecs[1]  = mk(1, 0, 0, 5'd3,  8'h00, 0, 5'd0,  8'h00, 1, 8'hA5, 0, 0);
    vecs[2]  = mk(1, 0, 0, 5'd3,  8'h00, 0, 5'd0,  8'h00, 1, 8'hA5, 0, 0);
    vecs[3]  = mk(1, 0, 0, 5'd3,  8'h00, 0, 5'd0,  8'h00, 1, 8'hA5, 0, 0);
    vecs[4]  = mk(0, 0, 0, 5'd3,  8'h00, 0, 5'd0,  8'h00, 0, 8'hA5, 0, 0);
    vecs[5]  = mk(0, 1, 1, 5'd20, 8'h5A, 0, 5'd0,  8'h00, 0, 8'hA5, 0, 0);
    vecs[6]  = mk(1, 0, 0, 5'd20, 8'h00, 0, 5'd0,  8'h00, 1, 8'h5A, 0, 0);
    vecs[7]  = mk(1, 0, 0, 5'd20, 8'h00, 1, 5'd20, 8'h77, 1, 8'h5A, 0, 1);
    vecs[8]  = mk(0, 0, 0, 5'd20, 8'h00, 0, 5'd0,  8'h00, 0, 8'h5A, 0, 0);
    vecs[9]  = mk(1, 0, 0, 5'd20, 8'h00, 0, 5'd0,  8'h00, 1, 8'h5A, 0, 0);
    vecs[10] = mk(1, 0, 0, 5'd3,  8'h00, 0, 5'd0,  8'h00, 1, 8'hA5, 0, 0);
    vecs[11] = mk(0, 0, 0, 5'd3,  8'h00, 0, 5'd0,  8'h00, 0, 8'hA5, 0, 0);
    vecs[12] = mk(0, 0, 0, 5'd0,  8'h00, 1, 5'd20, 8'h77, 0, 8'hA5, 0, 0);
    vecs[13] = mk(1, 0, 0, 5'd20, 8'h00, 0, 5'd0,  8'h00, 1, 8'h77, 0, 0);
    vecs[14] = mk(1, 1, 1, 5'd20, 8'hFF, 0, 5'd0,  8'h00, 1, 8'h77, 1, 0);
    vecs[15] = mk(0, 0, 0, 5'd20, 8'h00, 0, 5'd0,  8'h00, 0, 8'h77, 1, 0);
    vecs[16] = mk(1, 0, 0, 5'd20, 8'h00, 0, 5'd0,  8'h00, 1, 8'h77, 1, 0);
    vecs[17] = mk(0, 0, 0, 5'd20, 8'h00, 0, 5'd0,  8'h00, 0, 8'h77, 1, 0);

    drive1(0, 0, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00);
    drive2(0, 0, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("reset data_out", 32'(b1.data_out), 32'h00);
    check("reset data_valid", 32'(b1.data_valid), 32'd0);
    check("reset proto_err", 32'(b1.proto_err), 32'd0);
    check("reset ld_busy", 32'(b1.ld_busy), 32'd0);
    check("reset state", 32'(b1.dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      cyc1(vecs[i].rd, vecs[i].wr, vecs[i].de, vecs[i].addr, vecs[i].din,
           vecs[i].ld, vecs[i].la, vecs[i].ldd);
      exp_q.push_back(vecs[i].ed);
      check($sformatf("v%0d valid", i), 32'(b1.data_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d err", i), 32'(b1.proto_err), 32'(vecs[i].ee));
      check($sformatf("v%0d busy", i), 32'(b1.ld_busy), 32'(vecs[i].eb));
      check($sformatf("v%0d data", i), 32'(b1.data_out), 32'(exp_q.pop_front()));
    end

    // sticky error clears only on reset
    reset_pulse();

    // write without data_e: flagged and suppressed
    cyc1(0, 0, 0, 5'd0, 8'h00, 1, 5'd21, 8'h42);
    cyc1(0, 1, 0, 5'd21, 8'h99, 0, 5'd0, 8'h00);
    check("nodata err", 32'(b1.proto_err), 32'd1);
    cyc1(1, 0, 0, 5'd21, 8'h00, 0, 5'd0, 8'h00);
    check("nodata valid", 32'(b1.data_valid), 32'd1);
    check("nodata word", 32'(b1.data_out), 32'h42);
    cyc1(0, 0, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00);
    reset_pulse();

    // program-space write protect
    cyc1(0, 0, 0, 5'd0, 8'h00, 1, 5'd4, 8'h44);
    cyc1(0, 1, 1, 5'd4, 8'h5E, 0, 5'd0, 8'h00);
    check("wp low err", 32'(b1.proto_err), 32'(PROT));
    cyc1(0, 1, 1, 5'd16, 8'h16, 0, 5'd0, 8'h00);
    check("wp high err", 32'(b1.proto_err), 32'(PROT));
    cyc1(1, 0, 0, 5'd4, 8'h00, 0, 5'd0, 8'h00);
    check("wp low word", 32'(b1.data_out), PROT ? 32'h44 : 32'h5E);
    cyc1(1, 0, 0, 5'd16, 8'h00, 0, 5'd0, 8'h00);
    check("wp high word", 32'(b1.data_out), 32'h16);
    check("wp high valid", 32'(b1.data_valid), 32'd1);

    // asynchronous reset in the middle of a held read
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst valid", 32'(b1.data_valid), 32'd0);
    check("midrst data", 32'(b1.data_out), 32'h00);
    check("midrst state", 32'(b1.dbg_state), 32'(IDLE));
    @(negedge clk);
    drive1(0, 0, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc1(1, 0, 0, 5'd16, 8'h00, 0, 5'd0, 8'h00);
    check("mem kept", 32'(b1.data_out), 32'h16);
    cyc1(0, 0, 0, 5'd0, 8'h00, 0, 5'd0, 8'h00);

    // READ_LAT=2 instance: latency and address-change gap
    cyc2(0, 5'd0, 1, 5'd7, 8'h3C);
    cyc2(0, 5'd0, 1, 5'd8, 8'h11);
    cyc2(1, 5'd7, 0, 5'd0, 8'h00);
    check("lat2 e1 valid", 32'(b2.data_valid), 32'd0);
    check("lat2 e1 state", 32'(b2.dbg_state), 32'(RD_WAIT));
    cyc2(1, 5'd7, 0, 5'd0, 8'h00);
    exp_q.push_back(8'h3C);
    check("lat2 e2 valid", 32'(b2.data_valid), 32'd1);
    check("lat2 e2 data", 32'(b2.data_out), 32'(exp_q.pop_front()));
    cyc2(1, 5'd7, 0, 5'd0, 8'h00);
    check("lat2 hold valid", 32'(b2.data_valid), 32'd1);
    check("lat2 hold data", 32'(b2.data_out), 32'h3C);
    cyc2(1, 5'd8, 0, 5'd0, 8'h00);
    check("lat2 gap valid", 32'(b2.data_valid), 32'd0);
    cyc2(1, 5'd8, 0, 5'd0, 8'h00);
    exp_q.push_back(8'h11);
    check("lat2 new valid", 32'(b2.data_valid), 32'd1);
    check("lat2 new data", 32'(b2.data_out), 32'(exp_q.pop_front()));
    cyc2(0, 5'd8, 0, 5'd0, 8'h00);
    check("lat2 fall valid", 32'(b2.data_valid), 32'd0);
    check("lat2 fall data", 32'(b2.data_out), 32'h11);
    check("lat2 fall state", 32'(b2.dbg_state), 32'(IDLE));

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
Memory-side responder for the 8-phase accumulator CPU bus: answers the controller's sel/rd/wr/data_e strobes with instruction and operand reads and STO writes. Contains a 32x8 word store, a read-latency FSM and a protocol checker. Sits between the CPU address mux/data bus and the testbench or program loader. A side preload port fills memory before the CPU runs.

Parameters:
ADDR_W, 5, address width; depth = 2**ADDR_W words
DATA_W, 8, word width (3-bit opcode + 5-bit operand address)
READ_LAT, 1, cycles from read start to data_valid; legal range 1..2
PROT_LIMIT, 16, first writable address when the write-protect feature is compiled in

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
addr  input  ADDR_W  CPU address (PC when sel=1, IR operand field otherwise)
rd  input  1  read strobe; held high for several consecutive cycles
wr  input  1  write strobe; single cycle in phase 7 of STO
data_in  input  DATA_W  CPU write data; meaningful only while data_e=1
data_e  input  1  CPU drives data_in
data_out  output  DATA_W  read data to CPU
data_valid  output  1  data_out holds the word for the current read
proto_err  output  1  sticky protocol-violation flag
ld_en  input  1  preload write enable
ld_addr  input  ADDR_W  preload address
ld_data  input  DATA_W  preload data
ld_busy  output  1  preload refused this cycle (bus active)

Behaviour:
- Reset (async, rst_n=0): state IDLE, data_out=0, data_valid=0, proto_err=0, ld_busy=0, rd_q=0. Memory contents are not cleared.
- FSM states: IDLE, RD_WAIT, RD_HOLD.
- Read start: rd=1 and (rd_q=0 or addr != latched addr). On read start, latch addr, load the latency counter with READ_LAT-1, and enter RD_WAIT. If READ_LAT=1, go straight to RD_HOLD on the next edge.
- RD_WAIT: decrement the counter. At 0, register mem[latched addr] into data_out, set data_valid=1, and enter RD_HOLD. Data is therefore valid READ_LAT cycles after rd rises: with READ_LAT=1 it is valid in phase 2, when ld_ir first samples.
- RD_HOLD: data_out and data_valid stay stable while rd=1 and addr is unchanged.
  - Address change with rd=1: restart the read (RD_WAIT or RD_HOLD per latency) and drop data_valid for the gap.
  - rd falls: data_valid=0 next cycle, state IDLE. data_out keeps its last value.
- Write: on any cycle with wr=1, data_e=1 and rd=0, write mem[addr] <= data_in at the clock edge. There is no response latency. State is unaffected.
- Protocol errors set proto_err (sticky until reset), and the access is suppressed:
  - rd=1 and wr=1 in the same cycle: no write; read still served.
  - wr=1 with data_e=0.
  - Read-after-write: a same-cycle read of the address being written returns the OLD data. The controller never does this; it is not an error.
- Preload: accepted only when rd=0 and wr=0 and the state is IDLE. It writes mem[ld_addr] <= ld_data.
  - If ld_en=1 while the bus is active: the write is ignored and ld_busy=1 for that cycle (registered, visible the cycle after).
  - CPU and preload never write in the same cycle.
- rd_q is the registered rd, used for edge detection.
- Mid-operation reset: the FSM returns to IDLE at once and any in-flight read is dropped.

Optional Feature:
MEM_WRPROT_EN
- Defined: CPU writes (wr path) to addr < PROT_LIMIT are discarded and set proto_err. Program space is read-only to STO. The preload port is unaffected.
- Undefined: all addresses are writable by the CPU; PROT_LIMIT is unused.

Decomposition:
- Package cpu_mem_pkg holds:
  - ADDR_W and DATA_W constants
  - the rsp_state_t enum {IDLE, RD_WAIT, RD_HOLD}
  - opcode constants shared with the controller (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP = 0..7)
- One sub-module, cpu_mem_array: 2**ADDR_W x DATA_W storage with one write port (muxed CPU/preload) and one synchronous read port.
- The FSM, latency counter, protocol checker and preload arbitration stay in the top module.

Test Plan:
- Preload mem[3]=8'hA5; rd=1 at addr 3 for 3 cycles -> data_valid=1 and data_out=8'hA5 from cycle 2 (READ_LAT=1); data_valid=0 one cycle after rd falls.
- READ_LAT=2, mem[7]=8'h3C; rd held at addr 7 -> data_valid first seen 2 cycles after rd rises. Change addr to 8 (mem[8]=8'h11) mid-read -> one-cycle valid gap, then 8'h11.
- wr=1, data_e=1, addr 20, data_in=8'h5A -> a following read of 20 returns 8'h5A; proto_err stays 0.
- rd=1 and wr=1 together at addr 20 with data_in=8'hFF -> mem[20] unchanged, proto_err=1 until rst_n pulses low.
- ld_en=1 while rd=1 -> ld_busy=1 next cycle and the target word is unchanged. The same preload with the bus idle succeeds.
- With MEM_WRPROT_EN: STO to addr 4 -> mem[4] unchanged and proto_err=1. STO to addr 16 -> write succeeds.
